// File: rtl/lcd_pkg.sv
// Shared constants and FSM encoding for the LCD shadow driver.
// The optional dirty-row skip is enabled by defining LCD_DIRTY_SKIP_EN.
package lcd_pkg;

    localparam int LCD_ROWS = 2;
    localparam int LCD_COLS = 16;

    localparam logic [7:0] CMD_FUNC_SET = 8'h38;
    localparam logic [7:0] CMD_DISP_ON  = 8'h0C;
    localparam logic [7:0] CMD_ENTRY    = 8'h06;
    localparam logic [7:0] CMD_CLEAR    = 8'h01;
    localparam logic [7:0] CMD_ROW0     = 8'h80;
    localparam logic [7:0] CMD_ROW1     = 8'hC0;
    localparam logic [7:0] CHAR_BLANK   = 8'h20;

    typedef enum logic [2:0] {
        ST_INIT_WAIT,
        ST_INIT_CMD,
        ST_CLR_WAIT,
        ST_ADDR,
        ST_CHAR,
        ST_SCAN_IDLE
    } lcd_state_t;

    function automatic logic [7:0] init_cmd(input logic [1:0] idx);
        case (idx)
            2'd0:    init_cmd = CMD_FUNC_SET;
            2'd1:    init_cmd = CMD_DISP_ON;
            2'd2:    init_cmd = CMD_ENTRY;
            default: init_cmd = CMD_CLEAR;
        endcase
    endfunction

endpackage

// File: rtl/lcd_shadow_buf.sv
// 2-row shadow character buffer: capture write port, async scanner read port.
// Per-row dirty flags exist only when LCD_DIRTY_SKIP_EN is defined.
module lcd_shadow_buf
    import lcd_pkg::*;
#(
    parameter  int COLS  = LCD_COLS,
    localparam int COL_W = $clog2(COLS),
    localparam int PTR_W = $clog2(COLS + 1)
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             i_rw,
    input  logic             i_rs,
    input  logic [7:0]       i_data,
    input  logic             i_rd_row,
    input  logic [COL_W-1:0] i_rd_col,
    output logic [7:0]       o_rd_data
`ifdef LCD_DIRTY_SKIP_EN
    ,
    input  logic [1:0]       i_dirty_clr,
    output logic [1:0]       o_dirty
`endif
);

    logic [7:0]       r_cell [LCD_ROWS][COLS];
    logic             r_row;
    logic [PTR_W-1:0] r_col;
    logic             w_wr_en;
    logic [COL_W-1:0] w_wr_col;

    // A column equal to COLS means the pointer ran off-screen; chars are dropped.
    assign w_wr_en  = !i_rw && i_rs && (r_col < PTR_W'(COLS));
    assign w_wr_col = r_col[COL_W-1:0];

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_row <= 1'b0;
            r_col <= '0;
            for (int r = 0; r < LCD_ROWS; r++) begin
                for (int c = 0; c < COLS; c++) begin
                    r_cell[r][c] <= CHAR_BLANK;
                end
            end
        end else if (!i_rw) begin
            if (!i_rs) begin
                if (i_data[7]) begin
                    r_row <= i_data[6];
                    r_col <= PTR_W'(i_data[3:0]);
                end
            end else if (w_wr_en) begin
                r_cell[r_row][w_wr_col] <= i_data;
                r_col                   <= r_col + PTR_W'(1);
            end
        end
    end

    assign o_rd_data = r_cell[i_rd_row][i_rd_col];

`ifdef LCD_DIRTY_SKIP_EN
    logic [1:0] r_dirty;
    logic [1:0] w_dirty_set;

    // A new differing write wins over a same-cycle clear so no change is lost.
    assign w_dirty_set = (w_wr_en && (i_data != r_cell[r_row][w_wr_col])) ?
                         {r_row, ~r_row} : 2'b00;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_dirty <= 2'b11;
        end else begin
            r_dirty <= (r_dirty & ~i_dirty_clr) | w_dirty_set;
        end
    end

    assign o_dirty = r_dirty;
`endif

endmodule

// File: rtl/lcd_shadow_driver.sv
// Captures the upstream RW/RS/DATA stream into a shadow buffer and refreshes an
// HD44780-style LCD from it. Define LCD_DIRTY_SKIP_EN to refresh only changed rows.
module lcd_shadow_driver
    import lcd_pkg::*;
#(
    parameter int INIT_WAIT_CYC = 20,
    parameter int CLR_WAIT_CYC  = 2,
    parameter int COLS          = LCD_COLS
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       RW_IN,
    input  logic       RS_IN,
    input  logic [7:0] DATA_IN,
    output logic       LCD_E,
    output logic       LCD_RS,
    output logic       LCD_RW,
    output logic [7:0] LCD_DATA,
    output logic       INIT_DONE
);

    localparam int CNT_W = 16;
    localparam int COL_W = $clog2(COLS);

    lcd_state_t       r_state, w_state_nx;
    logic             r_phase, w_phase_nx;
    logic [CNT_W-1:0] r_cnt, w_cnt_nx;
    logic             r_row, w_row_nx;
    logic             r_e, w_e_nx;
    logic             r_rs, w_rs_nx;
    logic             r_rw;
    logic [7:0]       r_data, w_data_nx;
    logic             r_done, w_done_nx;
    logic             w_goto_scan, w_pref, w_sel_ok, w_sel_row;
    logic             w_rd_row;
    logic [COL_W-1:0] w_rd_col;
    logic [7:0]       w_rd_data;

    // Read address comes from current state so the fetch never loops through next-state.
    assign w_rd_row = r_row;
    assign w_rd_col = (r_state == ST_CHAR) ? r_cnt[COL_W-1:0] + COL_W'(1) : '0;

`ifdef LCD_DIRTY_SKIP_EN
    logic [1:0] w_dirty, w_dirty_clr;
    assign w_dirty_clr = (r_state == ST_ADDR && !r_phase) ? {r_row, ~r_row} : 2'b00;
`endif

    lcd_shadow_buf #(.COLS(COLS)) u_buf (
        .CLK         (CLK),
        .RESET       (RESET),
        .i_rw        (RW_IN),
        .i_rs        (RS_IN),
        .i_data      (DATA_IN),
        .i_rd_row    (w_rd_row),
        .i_rd_col    (w_rd_col),
        .o_rd_data   (w_rd_data)
`ifdef LCD_DIRTY_SKIP_EN
        ,
        .i_dirty_clr (w_dirty_clr),
        .o_dirty     (w_dirty)
`endif
    );

    always_comb begin
        w_state_nx  = r_state;
        w_phase_nx  = r_phase;
        w_cnt_nx    = r_cnt;
        w_row_nx    = r_row;
        w_e_nx      = 1'b0;
        w_rs_nx     = r_rs;
        w_data_nx   = r_data;
        w_done_nx   = r_done;
        w_goto_scan = 1'b0;
        w_pref      = ~r_row;
        w_sel_ok    = 1'b0;
        w_sel_row   = 1'b0;

        case (r_state)
            ST_INIT_WAIT: begin
                if (r_cnt == CNT_W'(INIT_WAIT_CYC - 1)) begin
                    w_state_nx = ST_INIT_CMD;
                    w_phase_nx = 1'b0;
                    w_cnt_nx   = '0;
                    w_rs_nx    = 1'b0;
                    w_data_nx  = init_cmd(2'd0);
                end else begin
                    w_cnt_nx = r_cnt + CNT_W'(1);
                end
            end
            ST_INIT_CMD: begin
                if (!r_phase) begin
                    w_phase_nx = 1'b1;
                    w_e_nx     = 1'b1;
                end else if (r_cnt == CNT_W'(3)) begin
                    w_state_nx = ST_CLR_WAIT;
                    w_phase_nx = 1'b0;
                    w_cnt_nx   = '0;
                end else begin
                    w_phase_nx = 1'b0;
                    w_cnt_nx   = r_cnt + CNT_W'(1);
                    w_data_nx  = init_cmd(r_cnt[1:0] + 2'd1);
                end
            end
            ST_CLR_WAIT: begin
                if (r_cnt == CNT_W'(CLR_WAIT_CYC - 1)) begin
                    w_done_nx   = 1'b1;
                    w_goto_scan = 1'b1;
                    w_pref      = 1'b0;
                end else begin
                    w_cnt_nx = r_cnt + CNT_W'(1);
                end
            end
            ST_ADDR: begin
                if (!r_phase) begin
                    w_phase_nx = 1'b1;
                    w_e_nx     = 1'b1;
                end else begin
                    w_state_nx = ST_CHAR;
                    w_phase_nx = 1'b0;
                    w_cnt_nx   = '0;
                    w_rs_nx    = 1'b1;
                    w_data_nx  = w_rd_data;
                end
            end
            ST_CHAR: begin
                if (!r_phase) begin
                    w_phase_nx = 1'b1;
                    w_e_nx     = 1'b1;
                end else if (r_cnt == CNT_W'(COLS - 1)) begin
                    w_goto_scan = 1'b1;
                end else begin
                    w_phase_nx = 1'b0;
                    w_cnt_nx   = r_cnt + CNT_W'(1);
                    w_data_nx  = w_rd_data;
                end
            end
            ST_SCAN_IDLE: begin
                w_goto_scan = 1'b1;
            end
            default: begin
                w_state_nx = ST_INIT_WAIT;
                w_cnt_nx   = '0;
                w_phase_nx = 1'b0;
            end
        endcase

        // Pick the next row to refresh; without dirty skip it is always the preferred one.
        if (w_goto_scan) begin
`ifdef LCD_DIRTY_SKIP_EN
            if (w_dirty[w_pref]) begin
                w_sel_ok  = 1'b1;
                w_sel_row = w_pref;
            end else if (w_dirty[~w_pref]) begin
                w_sel_ok  = 1'b1;
                w_sel_row = ~w_pref;
            end
`else
            w_sel_ok  = 1'b1;
            w_sel_row = w_pref;
`endif
            if (w_sel_ok) begin
                w_state_nx = ST_ADDR;
                w_phase_nx = 1'b0;
                w_cnt_nx   = '0;
                w_row_nx   = w_sel_row;
                w_rs_nx    = 1'b0;
                w_data_nx  = w_sel_row ? CMD_ROW1 : CMD_ROW0;
            end else begin
                w_state_nx = ST_SCAN_IDLE;
                w_phase_nx = 1'b0;
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state <= ST_INIT_WAIT;
            r_phase <= 1'b0;
            r_cnt   <= '0;
            r_row   <= 1'b0;
            r_e     <= 1'b0;
            r_rs    <= 1'b0;
            r_rw    <= 1'b0;
            r_data  <= 8'h00;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_phase <= w_phase_nx;
            r_cnt   <= w_cnt_nx;
            r_row   <= w_row_nx;
            r_e     <= w_e_nx;
            r_rs    <= w_rs_nx;
            r_rw    <= 1'b0;
            r_data  <= w_data_nx;
            r_done  <= w_done_nx;
        end
    end

    assign LCD_E     = r_e;
    assign LCD_RS    = r_rs;
    assign LCD_RW    = r_rw;
    assign LCD_DATA  = r_data;
    assign INIT_DONE = r_done;

endmodule

// File: tb/tb_lcd_shadow_driver.sv
// Self-checking bench for lcd_shadow_driver with a cell-level shadow model.
// Define LCD_DIRTY_SKIP_EN for both bench and RTL to exercise the dirty-skip build.
module tb_lcd_shadow_driver;

    localparam int INIT_WAIT = 20;
    localparam int NCOLS     = 16;

    logic       CLK = 1'b0;
    logic       RESET = 1'b0;
    logic       RW_IN = 1'b1;
    logic       RS_IN = 1'b0;
    logic [7:0] DATA_IN = 8'h00;
    logic       LCD_E, LCD_RS, LCD_RW, INIT_DONE;
    logic [7:0] LCD_DATA;

    int n_pass  = 0;
    int n_total = 0;
    int g_cyc   = 0;

    logic [7:0] m_cell [2][NCOLS];
    int         m_row, m_col;
    logic [7:0] init_tail [3] = '{8'h0C, 8'h06, 8'h01};

    lcd_shadow_driver dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .RW_IN     (RW_IN),
        .RS_IN     (RS_IN),
        .DATA_IN   (DATA_IN),
        .LCD_E     (LCD_E),
        .LCD_RS    (LCD_RS),
        .LCD_RW    (LCD_RW),
        .LCD_DATA  (LCD_DATA),
        .INIT_DONE (INIT_DONE)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < NCOLS; c++) m_cell[r][c] = 8'h20;
        m_row = 0;
        m_col = 0;
    endtask

    task automatic model_cap(input logic rw, input logic rs, input logic [7:0] d);
        if (!rw) begin
            if (!rs) begin
                if (d[7]) begin
                    m_row = int'(d[6]);
                    m_col = int'(d[3:0]);
                end
            end else if (m_col < NCOLS) begin
                m_cell[m_row][m_col] = d;
                m_col++;
            end
        end
    endtask

    // Drive one cycle of upstream input, then sample on the following falling edge.
    task automatic cyc(input logic rw, input logic rs, input logic [7:0] d);
        RW_IN   = rw;
        RS_IN   = rs;
        DATA_IN = d;
        model_cap(rw, rs, d);
        @(negedge CLK);
        g_cyc++;
    endtask

    task automatic next_write(output logic srs, output logic [7:0] sd,
                              output logic prs, output logic [7:0] pd, output bit ok);
        logic       pe;
        logic       hrs;
        logic [7:0] hd;
        ok = 1'b0; srs = 1'b0; sd = 8'h00; prs = 1'b0; pd = 8'h00;
        for (int i = 0; i < 8 && !ok; i++) begin
            pe  = LCD_E;
            hrs = LCD_RS;
            hd  = LCD_DATA;
            cyc(1'b1, 1'b0, 8'h00);
            if (!pe && LCD_E) begin
                ok  = 1'b1;
                srs = hrs;
                sd  = hd;
                prs = LCD_RS;
                pd  = LCD_DATA;
            end
        end
    endtask

    task automatic expect_write(input string tag, input logic rs, input logic [7:0] d);
        logic       srs, prs;
        logic [7:0] sd, pd;
        bit         ok;
        next_write(srs, sd, prs, pd, ok);
        check(tag, {12'h0, ok, srs, sd, prs, pd}, {12'h0, 1'b1, rs, d, rs, d});
    endtask

    task automatic check_frame(input string tag);
        logic       srs, prs;
        logic [7:0] sd, pd;
        bit         ok;
        bit         found = 1'b0;
        int         t0;
        for (int i = 0; i < 40 && !found; i++) begin
            next_write(srs, sd, prs, pd, ok);
            if (ok && !prs && pd == 8'h80) found = 1'b1;
        end
        check({tag, "_sync"}, {31'h0, found}, 32'h1);
        if (found) begin
            t0 = g_cyc;
            for (int c = 0; c < NCOLS; c++)
                expect_write($sformatf("%s_r0c%0d", tag, c), 1'b1, m_cell[0][c]);
            expect_write({tag, "_addr1"}, 1'b0, 8'hC0);
            for (int c = 0; c < NCOLS; c++)
                expect_write($sformatf("%s_r1c%0d", tag, c), 1'b1, m_cell[1][c]);
`ifndef LCD_DIRTY_SKIP_EN
            expect_write({tag, "_addr0_next"}, 1'b0, 8'h80);
            check({tag, "_period"}, g_cyc - t0, 68);
`endif
            check({tag, "_rw"}, {31'h0, LCD_RW}, 32'h0);
        end
    endtask

    task automatic init_seq(input string tag);
        int e_hi = 0;
        RESET = 1'b1;
        for (int i = 1; i < INIT_WAIT; i++) begin
            cyc(1'b1, 1'b0, 8'h00);
            if (LCD_E) e_hi++;
        end
        check({tag, "_wait_e"}, e_hi, 0);
        check({tag, "_wait_done"}, {31'h0, INIT_DONE}, 32'h0);
        cyc(1'b1, 1'b0, 8'h00);
        check({tag, "_setup38"}, {LCD_E, LCD_RS, LCD_DATA}, {2'b00, 8'h38});
        cyc(1'b1, 1'b0, 8'h00);
        check({tag, "_pulse38"}, {LCD_E, LCD_RS, LCD_DATA}, {2'b10, 8'h38});
        for (int k = 0; k < 3; k++)
            expect_write($sformatf("%s_cmd%0d", tag, k + 1), 1'b0, init_tail[k]);
        cyc(1'b1, 1'b0, 8'h00);
        check({tag, "_clr_busy"}, {LCD_E, INIT_DONE}, 2'b00);
        cyc(1'b1, 1'b0, 8'h00);
        cyc(1'b1, 1'b0, 8'h00);
        check({tag, "_done"}, {INIT_DONE, LCD_E, LCD_RS, LCD_DATA}, {3'b100, 8'h80});
    endtask

    task automatic count_idle_e(input string tag, input int n);
        int e_hi = 0;
        for (int i = 0; i < n; i++) begin
            cyc(1'b1, 1'b0, 8'h00);
            if (LCD_E) e_hi++;
        end
        check(tag, e_hi, 0);
    endtask

    initial begin
        logic       srs, prs;
        logic [7:0] sd, pd;
        bit         ok;
        int         k;

        model_reset();
        @(negedge CLK);
        @(negedge CLK);
        check("reset_outputs", {LCD_E, LCD_RS, LCD_RW, LCD_DATA, INIT_DONE}, 32'h0);

        init_seq("init");
        check_frame("blank");

`ifdef LCD_DIRTY_SKIP_EN
        count_idle_e("skip_idle_a", 40);
        cyc(1'b0, 1'b0, 8'hC3);
        cyc(1'b0, 1'b1, 8'h41);
        expect_write("skip_addr1", 1'b0, 8'hC0);
        for (int c = 0; c < NCOLS; c++)
            expect_write($sformatf("skip_r1c%0d", c), 1'b1, m_cell[1][c]);
        count_idle_e("skip_idle_b", 40);
`else
        for (int i = 0; i < 100; i++) cyc(1'b1, 1'b1, 8'h02);
        check_frame("rw_idle");

        cyc(1'b0, 1'b0, 8'h80);
        cyc(1'b0, 1'b1, 8'h54);
        cyc(1'b0, 1'b1, 8'h6F);
        check_frame("to");

        cyc(1'b0, 1'b0, 8'hC0);
        for (int i = 0; i < 18; i++) cyc(1'b0, 1'b1, 8'(8'h41 + i));
        check_frame("row1_full");

        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 40; i++) begin
                k = $urandom_range(0, 9);
                if (k < 2)       cyc(1'b1, 1'($urandom), 8'($urandom));
                else if (k == 2) cyc(1'b0, 1'b0, {1'b1, 1'($urandom), 2'($urandom), 4'($urandom)});
                else if (k == 3) cyc(1'b0, 1'b0, {1'b0, 7'($urandom)});
                else             cyc(1'b0, 1'b1, 8'($urandom_range(33, 126)));
            end
            check_frame($sformatf("rand%0d", r));
        end

        next_write(srs, sd, prs, pd, ok);
        check("rst_pulse_seen", {31'h0, ok & LCD_E}, 32'h1);
        RESET = 1'b0;
        #1;
        check("rst_async", {LCD_E, LCD_RS, LCD_DATA, INIT_DONE}, 32'h0);
        model_reset();
        @(negedge CLK);
        init_seq("reinit");
        check_frame("after_reset");
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
